z80_ret_unit: RTL
=================

Name: z80_ret_unit

Overview:
Multi-cycle execution engine for every Z80 return form: RET, RET cc, RETI and RETN, including the undocumented ED mirrors of RETN. The decoder starts it, it evaluates the condition against F, and it pops the return address through a wait-stated 8-bit read port. It returns new IP/SP plus IFF1 and RETI side-effects. It sits beside the core datapath, and its outputs must match the z80fi spec modules bit-for-bit.

Parameters:
ADDR_WIDTH, 16, width of IP/SP/mem_addr; must be >=16; the popped address is zero-extended.
COND_DELAY, 1, cycles spent in EVAL before the taken/not-taken decision (>=1).
MAX_WAIT, 0, consecutive un-acked read cycles before abort; 0 disables the timeout.

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous, active-low reset
start  in  1  request; accepted only when busy=0
prefix_ed  in  1  opcode was ED-prefixed
opcode  in  8  opcode byte after any prefix
f_in  in  8  flags register F
sp_in / ip_in  in  ADDR_WIDTH  SP and IP of the instruction
iff2_in  in  1  IFF2
mem_rd  out  1  read request
mem_addr  out  ADDR_WIDTH  read address
mem_ack  in  1  read complete; mem_rdata is valid this cycle
mem_rdata  in  8  read data
busy  out  1  from accept through the done cycle inclusive
done  out  1  one-cycle completion pulse
ip_out / sp_out  out  ADDR_WIDTH  results; valid while done=1
iff1_we / iff1_out  out  1  IFF1 write strobe and value (RETI/RETN)
reti  out  1  RETI pulse for the interrupt daisy chain, coincident with done
illegal  out  1  opcode is not a return form, coincident with done
timeout  out  1  read aborted, coincident with done

Behaviour:
- Reset (async, mid-operation included): state IDLE; every output 0, including mem_rd, which drops immediately.
- States: IDLE, EVAL, READ_LO, READ_HI, DONE.
- Start handling:
  - start is sampled in IDLE; on accept, opcode, prefix, F, SP, IP and IFF2 are latched.
  - start while busy=1 is ignored.
- Decode:
  - ~ED & C9 -> RET.
  - ~ED & 11ccc000 -> RET cc.
  - ED & 4D -> RETI.
  - ED & {45,55,5D,65,6D,75,7D} -> RETN.
  - Anything else -> DONE with illegal=1 and ip_out/sp_out equal to the latched inputs.
- Condition (RET cc):
  - cc 0/1 -> Z (bit 6), 2/3 -> C (bit 0), 4/5 -> P/V (bit 2), 6/7 -> S (bit 7).
  - The condition is met when F[bit]==cc[0]. Unconditional forms are always met.
- Sequencing:
  - EVAL lasts exactly COND_DELAY cycles.
  - Not met: go to DONE with ip_out=ip+1, sp_out=sp, and no memory access.
- READ_LO: mem_rd=1, mem_addr=sp; hold until mem_ack, then latch the low byte.
- READ_HI: mem_rd=1, mem_addr=sp+1; on mem_ack go to DONE.
- Taken result: ip_out={hi,lo}, sp_out=sp+2.
- Arithmetic wraps modulo 2^ADDR_WIDTH (sp=FFFF at width 16 reads FFFF then 0000; sp_out=0001).
- mem_rd deasserts the cycle after the second ack. An ack while mem_rd=0 is ignored.
- IFF1 and RETI:
  - RETN and RETI: iff1_we=1 and iff1_out=latched IFF2 during done.
  - RETI additionally: reti=1 during done.
- DONE lasts one cycle (done=1), then IDLE. busy falls the cycle after done, so the earliest restart is sampled then.
- Latency measured from the accept cycle (cycle 0), zero wait:
  - Taken: done at cycle 3+COND_DELAY.
  - Not taken: done at cycle 1+COND_DELAY.
  - Illegal: done at cycle 1.
  - Each wait cycle adds 1.
- Timeout (MAX_WAIT>0):
  - A counter counts consecutive mem_rd cycles without ack; it clears on ack.
  - On reaching MAX_WAIT: abort to DONE with timeout=1, ip_out/sp_out equal to the latched inputs, and iff1_we/reti=0.
- ip_out/sp_out hold their last values outside done.

Decomposition:
- Package z80_ret_pkg: state enum; flag bit constants FLAG_Z/C/PV/S; opcode constants RET, RETI, RETN mirror list; cond-code enum.
- Sub-module z80_ret_cond_eval (cc, F -> met): shared with the future JP cc/CALL cc units.

Test Plan:
1. RET C9, sp=1000, mem[1000]=34, mem[1001]=12, no waits, COND_DELAY=1 -> done at cycle 4; ip_out=1234, sp_out=1002; addresses 1000 then 1001.
2. RET NZ (C0) with F=40 -> done at cycle 2, ip_out=ip+1, sp unchanged, mem_rd never asserted. Then F=00 -> taken as in scenario 1.
3. RET M (F8), sp=FFFF, F=80, 3 wait cycles per read -> addresses FFFF then 0000; sp_out=0001; done at cycle 10.
4. ED 4D with iff2=1 -> done with reti=1, iff1_we=1, iff1_out=1. ED 5D -> same without reti. ED 4C -> illegal=1, no read.
5. MAX_WAIT=4, mem_ack held low -> timeout=1 after 4 read cycles; ip_out/sp_out equal the inputs; mem_rd drops. A start pulse during busy is ignored throughout.
6. reset_n low during READ_HI -> mem_rd, busy and done are 0 immediately. After release, a new RET completes correctly.

Source files
------------

// File: rtl/z80_ret_pkg.sv
`default_nettype none
// z80_ret_pkg: shared types, flag positions and opcode constants for the Z80 return unit.
// Revision: 1.0
package z80_ret_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_EVAL    = 3'd1,
    ST_READ_LO = 3'd2,
    ST_READ_HI = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  typedef enum logic [2:0] {
    K_ILLEGAL = 3'd0,
    K_RET     = 3'd1,
    K_RETCC   = 3'd2,
    K_RETI    = 3'd3,
    K_RETN    = 3'd4
  } kind_e;

  typedef enum logic [2:0] {
    CC_NZ = 3'd0,
    CC_Z  = 3'd1,
    CC_NC = 3'd2,
    CC_C  = 3'd3,
    CC_PO = 3'd4,
    CC_PE = 3'd5,
    CC_P  = 3'd6,
    CC_M  = 3'd7
  } cond_e;

  localparam int FLAG_C  = 0;
  localparam int FLAG_PV = 2;
  localparam int FLAG_Z  = 6;
  localparam int FLAG_S  = 7;

  localparam logic [7:0] OP_RET  = 8'hC9;
  localparam logic [7:0] OP_RETI = 8'h4D;

  // ED 45 is the documented RETN; the rest are undocumented mirrors.
  localparam int RETN_COUNT = 7;
  localparam logic [RETN_COUNT-1:0][7:0] OP_RETN =
    {8'h7D, 8'h75, 8'h6D, 8'h65, 8'h5D, 8'h55, 8'h45};

  function automatic kind_e decode_ret(input logic ed, input logic [7:0] op);
    kind_e k;
    k = K_ILLEGAL;
    if (!ed) begin
      if (op == OP_RET)
        k = K_RET;
      else if (op[7:6] == 2'b11 && op[2:0] == 3'b000)
        k = K_RETCC;
    end else if (op == OP_RETI) begin
      k = K_RETI;
    end else begin
      for (int i = 0; i < RETN_COUNT; i++)
        if (op == OP_RETN[i])
          k = K_RETN;
    end
    return k;
  endfunction

endpackage
`default_nettype wire

// File: rtl/z80_ret_unit_if.sv
`default_nettype none
// z80_ret_unit_if: decoder-side request/result bundle and 8-bit read port of the return unit.
// Revision: 1.0
interface z80_ret_unit_if #(
  parameter int ADDR_WIDTH = 16
);
  logic                  start;
  logic                  prefix_ed;
  logic [7:0]            opcode;
  logic [7:0]            f_in;
  logic [ADDR_WIDTH-1:0] sp_in;
  logic [ADDR_WIDTH-1:0] ip_in;
  logic                  iff2_in;
  logic                  mem_rd;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_ack;
  logic [7:0]            mem_rdata;
  logic                  busy;
  logic                  done;
  logic [ADDR_WIDTH-1:0] ip_out;
  logic [ADDR_WIDTH-1:0] sp_out;
  logic                  iff1_we;
  logic                  iff1_out;
  logic                  reti;
  logic                  illegal;
  logic                  timeout;

  modport slave (
    input  start, prefix_ed, opcode, f_in, sp_in, ip_in, iff2_in, mem_ack, mem_rdata,
    output mem_rd, mem_addr, busy, done, ip_out, sp_out, iff1_we, iff1_out, reti, illegal, timeout
  );

  modport master (
    output start, prefix_ed, opcode, f_in, sp_in, ip_in, iff2_in, mem_ack, mem_rdata,
    input  mem_rd, mem_addr, busy, done, ip_out, sp_out, iff1_we, iff1_out, reti, illegal, timeout
  );
endinterface
`default_nettype wire

// File: rtl/z80_ret_cond_eval.sv
`default_nettype none
// z80_ret_cond_eval: Z80 3-bit condition code against F; reused by the JP cc / CALL cc units.
// Revision: 1.0
module z80_ret_cond_eval
  import z80_ret_pkg::*;
(
  input  cond_e      i_cc,
  input  logic [7:0] i_f,
  output logic       o_met
);
  logic [1:0] w_sel;
  logic       w_flag;
  logic       w_unused_f;

  assign w_sel      = i_cc[2:1];
  assign w_unused_f = ^{i_f[5:3], i_f[1]};

  always_comb begin
    w_flag = 1'b0;
    case (w_sel)
      2'd0:    w_flag = i_f[FLAG_Z];
      2'd1:    w_flag = i_f[FLAG_C];
      2'd2:    w_flag = i_f[FLAG_PV];
      default: w_flag = i_f[FLAG_S];
    endcase
  end

  // Odd codes test for the flag set, even codes for it clear.
  assign o_met = (w_flag == i_cc[0]);
endmodule
`default_nettype wire

// File: rtl/z80_ret_unit.sv
`default_nettype none
// z80_ret_unit: multi-cycle engine for RET, RET cc, RETI and RETN (incl. ED mirrors).
// Revision: 1.0
module z80_ret_unit
  import z80_ret_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int COND_DELAY = 1,
  parameter int MAX_WAIT   = 0
) (
  input  logic          clk,
  input  logic          reset_n,
  z80_ret_unit_if.slave bus
);
  localparam int ECW = (COND_DELAY > 1) ? $clog2(COND_DELAY) : 1;
  localparam int WCW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [ECW-1:0] c_eval_last = ECW'(COND_DELAY - 1);
  localparam logic [WCW-1:0] c_wait_last = (MAX_WAIT > 0) ? WCW'(MAX_WAIT - 1) : '0;

  state_e                r_state;
  kind_e                 r_kind;
  cond_e                 r_cc;
  logic [7:0]            r_f;
  logic [ADDR_WIDTH-1:0] r_sp;
  logic [ADDR_WIDTH-1:0] r_ip;
  logic                  r_iff2;
  logic [7:0]            r_lo;
  logic [ECW-1:0]        r_eval_cnt;
  logic [WCW-1:0]        r_wait_cnt;
  logic                  r_mem_rd;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic                  r_busy;
  logic                  r_done;
  logic [ADDR_WIDTH-1:0] r_ip_out;
  logic [ADDR_WIDTH-1:0] r_sp_out;
  logic                  r_iff1_we;
  logic                  r_iff1_out;
  logic                  r_reti;
  logic                  r_illegal;
  logic                  r_timeout;

  kind_e                 w_kind_in;
  logic                  w_cc_met;
  logic                  w_cond_met;
  logic                  w_wait_expire;
  logic                  w_sets_iff1;
  logic [ADDR_WIDTH-1:0] w_sp_p1;
  logic [ADDR_WIDTH-1:0] w_sp_p2;
  logic [ADDR_WIDTH-1:0] w_ip_p1;
  logic [ADDR_WIDTH-1:0] w_popped;

  z80_ret_cond_eval u_cond (
    .i_cc  (r_cc),
    .i_f   (r_f),
    .o_met (w_cc_met)
  );

  assign w_kind_in     = decode_ret(bus.prefix_ed, bus.opcode);
  assign w_cond_met    = (r_kind == K_RETCC) ? w_cc_met : 1'b1;
  assign w_wait_expire = (MAX_WAIT > 0) && !bus.mem_ack && (r_wait_cnt == c_wait_last);
  assign w_sets_iff1   = (r_kind == K_RETI) || (r_kind == K_RETN);
  assign w_sp_p1       = r_sp + ADDR_WIDTH'(1);
  assign w_sp_p2       = r_sp + ADDR_WIDTH'(2);
  assign w_ip_p1       = r_ip + ADDR_WIDTH'(1);
  assign w_popped      = ADDR_WIDTH'({bus.mem_rdata, r_lo});

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_kind     <= K_ILLEGAL;
      r_cc       <= CC_NZ;
      r_f        <= '0;
      r_sp       <= '0;
      r_ip       <= '0;
      r_iff2     <= 1'b0;
      r_lo       <= '0;
      r_eval_cnt <= '0;
      r_wait_cnt <= '0;
      r_mem_rd   <= 1'b0;
      r_mem_addr <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_ip_out   <= '0;
      r_sp_out   <= '0;
      r_iff1_we  <= 1'b0;
      r_iff1_out <= 1'b0;
      r_reti     <= 1'b0;
      r_illegal  <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_kind     <= w_kind_in;
            r_cc       <= cond_e'(bus.opcode[5:3]);
            r_f        <= bus.f_in;
            r_sp       <= bus.sp_in;
            r_ip       <= bus.ip_in;
            r_iff2     <= bus.iff2_in;
            r_eval_cnt <= '0;
            r_busy     <= 1'b1;
            if (w_kind_in == K_ILLEGAL) begin
              r_state   <= ST_DONE;
              r_done    <= 1'b1;
              r_illegal <= 1'b1;
              r_ip_out  <= bus.ip_in;
              r_sp_out  <= bus.sp_in;
            end else begin
              r_state <= ST_EVAL;
            end
          end
        end

        ST_EVAL: begin
          if (r_eval_cnt == c_eval_last) begin
            if (w_cond_met) begin
              r_state    <= ST_READ_LO;
              r_mem_rd   <= 1'b1;
              r_mem_addr <= r_sp;
              r_wait_cnt <= '0;
            end else begin
              r_state  <= ST_DONE;
              r_done   <= 1'b1;
              r_ip_out <= w_ip_p1;
              r_sp_out <= r_sp;
            end
          end else begin
            r_eval_cnt <= r_eval_cnt + ECW'(1);
          end
        end

        ST_READ_LO, ST_READ_HI: begin
          if (bus.mem_ack) begin
            r_wait_cnt <= '0;
            if (r_state == ST_READ_LO) begin
              r_lo       <= bus.mem_rdata;
              r_mem_addr <= w_sp_p1;
              r_state    <= ST_READ_HI;
            end else begin
              r_state    <= ST_DONE;
              r_mem_rd   <= 1'b0;
              r_done     <= 1'b1;
              r_ip_out   <= w_popped;
              r_sp_out   <= w_sp_p2;
              r_iff1_we  <= w_sets_iff1;
              r_iff1_out <= w_sets_iff1 & r_iff2;
              r_reti     <= (r_kind == K_RETI);
            end
          end else if (w_wait_expire) begin
            // Abort leaves architectural state untouched: report the original IP/SP.
            r_state   <= ST_DONE;
            r_mem_rd  <= 1'b0;
            r_done    <= 1'b1;
            r_timeout <= 1'b1;
            r_ip_out  <= r_ip;
            r_sp_out  <= r_sp;
          end else begin
            r_wait_cnt <= r_wait_cnt + WCW'(1);
          end
        end

        ST_DONE: begin
          r_state    <= ST_IDLE;
          r_busy     <= 1'b0;
          r_done     <= 1'b0;
          r_iff1_we  <= 1'b0;
          r_iff1_out <= 1'b0;
          r_reti     <= 1'b0;
          r_illegal  <= 1'b0;
          r_timeout  <= 1'b0;
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.mem_rd   = r_mem_rd;
  assign bus.mem_addr = r_mem_addr;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.ip_out   = r_ip_out;
  assign bus.sp_out   = r_sp_out;
  assign bus.iff1_we  = r_iff1_we;
  assign bus.iff1_out = r_iff1_out;
  assign bus.reti     = r_reti;
  assign bus.illegal  = r_illegal;
  assign bus.timeout  = r_timeout;
endmodule
`default_nettype wire
